prbs8_checker: RTL and testbench
================================

PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 16, consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter LOSS_WIN, default 64, window length in received bits for lock-loss evaluation.
REQ-003 SHALL have parameter LOSS_ERRS, default 8, errors within one window that force loss of lock.
REQ-004 SHALL have port clk_40M  input  1  system clock, 40 MHz.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port bit_valid  input  1  single-cycle strobe qualifying bit_in, at most once per clock, nominally once per 40 clocks.
REQ-007 SHALL have port bit_in  input  1  received serial data, meaningful only when bit_valid=1.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-009 SHALL have port locked  output  1  high while state is LOCKED.
REQ-010 SHALL have port err_pulse  output  1  one-cycle pulse per bit error detected in LOCKED.
REQ-011 SHALL have port err_count  output  16  saturating bit-error count.
REQ-012 SHALL have port loss_count  output  8  saturating count of lock-loss events.

Function
REQ-013 SHALL check a PRBS stream with polynomial x^8+x^4+x^3+x^2+1, period 255; 8-bit history h[7:0], h[0] = newest received bit; predicted bit p = h[7]^h[3]^h[2]^h[1].
REQ-014 SHALL act only on cycles with bit_valid=1; all state, counters and history SHALL hold otherwise.
REQ-015 SHALL implement FSM states HUNT, VERIFY, LOCKED.
REQ-016 HUNT: shift bit_in into h, increment fill_cnt; after the 8th valid bit go to VERIFY if the resulting h != 0x00, else stay in HUNT with fill_cnt held at 8.
REQ-017 VERIFY: shift bit_in into h; bit_in == p -> good_cnt+1; mismatch -> good_cnt = 0, stay VERIFY; good_cnt reaching LOCK_THRESH -> LOCKED; h becoming 0x00 -> HUNT.
REQ-018 LOCKED: shift p (not bit_in) into h (flywheel); bit_in != p -> err_pulse, err_count+1, win_err+1.
REQ-019 LOCKED: win_cnt counts valid bits 0..LOSS_WIN-1, then wraps; win_err clears on wrap.
REQ-020 win_err reaching LOSS_ERRS -> HUNT, fill_cnt = 0, loss_count+1; this SHALL take priority over a window wrap on the same bit.
REQ-021 Latency: locked, err_pulse, err_count and loss_count SHALL update on the clock edge that samples the qualifying bit_valid; all outputs registered.
REQ-022 err_count SHALL saturate at 0xFFFF; loss_count SHALL saturate at 0xFF.
REQ-023 err_clr alone -> err_count = 0; err_clr with an error on the same cycle -> err_count = 1.
REQ-024 Entering VERIFY or LOCKED SHALL clear good_cnt, win_cnt and win_err.

Reset
REQ-025 rst SHALL force: state HUNT, h = 0x00, fill_cnt = good_cnt = win_cnt = win_err = 0, locked = 0, err_pulse = 0, err_count = 0, loss_count = 0, on the next clk_40M edge, regardless of state, bit_valid or err_clr.
REQ-026 rst SHALL take priority over every other input; rst mid-LOCKED requires full reacquisition (8 fill + LOCK_THRESH bits).

Structure
REQ-027 Polynomial tap positions, seed value 0xFF and the FSM state encoding SHALL reside in a shared package, also used by the scrambler/descrambler blocks.
REQ-028 A single sub-module prbs8_predict (combinational p from h) SHALL be instantiated; the remainder is flat.

Verification
REQ-029 Generator seeded 0xFF, bit_valid every 40 clocks, first bits 1,1,1,1,1,1,1,1,0 -> locked rises at the 24th strobe; err_count = 0 after 1000 bits.
REQ-030 While locked, invert the single bit at locked index 100 -> exactly one err_pulse, err_count = 1, locked stays 1.
REQ-031 Invert 8 bits within one 64-bit window -> locked falls at the 8th error, loss_count = 1; relocks after 24 further clean bits.
REQ-032 bit_in constant 0 for 500 strobes -> state stays HUNT, locked = 0, err_count = 0.
REQ-033 err_clr asserted on the same cycle as an error with err_count = 5 -> err_count = 1; err_clr alone -> 0.
REQ-034 One-cycle rst while locked with err_count = 3 -> next cycle locked = 0, err_count = 0, loss_count = 0.

Source files
------------

// File: rtl/prbs8_pkg.sv
// PRBS-8 shared definitions: polynomial taps, generator seed, checker FSM encoding.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package prbs8_pkg;

  // x^8+x^4+x^3+x^2+1 with h[0] as the newest bit: predicted bit = h[7]^h[3]^h[2]^h[1]
  localparam logic [7:0] PRBS8_TAPS = 8'b1000_1110;
  localparam logic [7:0] PRBS8_SEED = 8'hFF;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic prbs8_next(input logic [7:0] hist);
    return ^(hist & PRBS8_TAPS);
  endfunction

endpackage

// File: rtl/prbs8_predict.sv
// Next-bit predictor for the PRBS-8 sequence from an 8-bit history.
// Latency: combinational.
// Backpressure: none.
// Ports: hist_i - history, bit 0 newest; pred_o - predicted next bit.
module prbs8_predict
  import prbs8_pkg::*;
(
  input  logic [7:0] hist_i,
  output logic       pred_o
);

  assign pred_o = prbs8_next(hist_i);

endmodule

// File: rtl/prbs8_checker.sv
// PRBS-8 receive checker: hunts for the sequence, verifies LOCK_THRESH predictions, then
//   flywheels in LOCKED counting bit errors; loses lock on LOSS_ERRS errors per LOSS_WIN bits.
// Latency: all outputs registered, updated on the edge that samples bit_valid.
// Backpressure: none; acts only on bit_valid cycles, holds state otherwise.
// Ports: clk_40M/rst (sync, active-high); bit_valid/bit_in serial input; err_clr clears
//   err_count; locked, err_pulse, err_count (sat 16b), loss_count (sat 8b) status outputs.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_ERRS   = 8
) (
  input  logic        clk_40M,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        err_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [7:0]  loss_count
);

  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  logic [1:0]    st_q, st_d;
  logic [7:0]    h_q, h_d;
  logic [3:0]    fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;
  logic          locked_q, locked_d;
  logic          pulse_q, pulse_d;
  logic [15:0]   errc_q, errc_d;
  logic [7:0]    loss_q, loss_d;
  logic          pred;
  logic          err_hit;

  prbs8_predict u_predict (
    .hist_i (h_q),
    .pred_o (pred)
  );

  always_comb begin
    st_d    = st_q;
    h_d     = h_q;
    fill_d  = fill_q;
    good_d  = good_q;
    win_d   = win_q;
    werr_d  = werr_q;
    loss_d  = loss_q;
    err_hit = 1'b0;

    if (bit_valid) begin
      case (st_q)
        ST_HUNT: begin
          h_d = {h_q[6:0], bit_in};
          if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
          // fill saturates at 8 so an all-zero history keeps retrying on every new bit
          if (fill_q >= 4'd7 && h_d != 8'h00) begin
            st_d   = ST_VERIFY;
            good_d = '0;
            win_d  = '0;
            werr_d = '0;
          end
        end
        ST_VERIFY: begin
          h_d = {h_q[6:0], bit_in};
          if (h_d == 8'h00) begin
            st_d   = ST_HUNT;
            fill_d = 4'd0;
          end else if (bit_in == pred) begin
            if (good_q == GW'(LOCK_THRESH - 1)) begin
              st_d   = ST_LOCKED;
              good_d = '0;
              win_d  = '0;
              werr_d = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          // flywheel: history follows the prediction so a bad bit cannot corrupt it
          h_d     = {h_q[6:0], pred};
          err_hit = (bit_in != pred);
          if (err_hit && werr_q == EW'(LOSS_ERRS - 1)) begin
            // loss wins over a window wrap on the same bit
            st_d   = ST_HUNT;
            fill_d = 4'd0;
            win_d  = '0;
            werr_d = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else if (win_q == WW'(LOSS_WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            if (err_hit) werr_d = werr_q + EW'(1);
          end
        end
        default: begin
          st_d   = ST_HUNT;
          fill_d = 4'd0;
        end
      endcase
    end

    pulse_d  = err_hit;
    locked_d = (st_d == ST_LOCKED);

    errc_d = errc_q;
    if (err_clr) begin
      errc_d = err_hit ? 16'd1 : 16'd0;
    end else if (err_hit && errc_q != 16'hFFFF) begin
      errc_d = errc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_40M) begin
    if (rst) begin
      st_q     <= ST_HUNT;
      h_q      <= 8'h00;
      fill_q   <= 4'd0;
      good_q   <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      errc_q   <= 16'd0;
      loss_q   <= 8'd0;
    end else begin
      st_q     <= st_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      good_q   <= good_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      errc_q   <= errc_d;
      loss_q   <= loss_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_count  = errc_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_prbs8_checker.sv
`timescale 1ns/1ps
module tb_prbs8_checker;

  logic        clk_40M = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        err_clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [7:0]  loss_count;

  always #12.5 clk_40M = ~clk_40M;

  prbs8_checker #(
    .LOCK_THRESH (16),
    .LOSS_WIN    (64),
    .LOSS_ERRS   (8)
  ) dut (
    .clk_40M    (clk_40M),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .loss_count (loss_count)
  );

  typedef struct {
    int          n;
    bit          inv;
    bit          clr;
    bit          e_lock;
    bit          e_pulse;
    logic [15:0] e_err;
    logic [7:0]  e_loss;
  } ev_t;

  localparam int NEV = 23;
  ev_t ev [NEV];

  int n_cmp = 0;
  int n_bad = 0;
  int cur_n = 0;

  logic [7:0] g;
  int         gcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s strobe=%0d actual=%0h required=%0h", name, cur_n, act, exp);
    end
  endtask

  task automatic gen_reset();
    g      = 8'hFF;
    gcount = 0;
  endtask

  // reference generator: first 8 bits are the seed, then g[7]^g[3]^g[2]^g[1]
  task automatic gen_next(output logic b);
    if (gcount < 8) b = 1'b1;
    else            b = g[7] ^ g[3] ^ g[2] ^ g[1];
    g = {g[6:0], b};
    gcount++;
  endtask

  // waits gap-1 idle cycles, presents one strobe, returns at the negedge after its sampling edge
  task automatic strobe(input logic b, input logic clr, input int gap);
    repeat (gap - 1) @(negedge clk_40M);
    bit_valid = 1'b1;
    bit_in    = b;
    err_clr   = clr;
    @(negedge clk_40M);
    bit_valid = 1'b0;
    err_clr   = 1'b0;
    bit_in    = ~b;
  endtask

  task automatic pulse_rst();
    @(negedge clk_40M);
    rst = 1'b1;
    @(negedge clk_40M);
    rst = 1'b0;
  endtask

  initial begin
    logic b;
    logic inv, clr;
    int   hit;
    logic saw_lock, saw_pulse;

    // n: strobe number since reset (lock at 24, locked index k = n-25; windows wrap at k%64==63)
    ev[0]  = '{23,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
    ev[1]  = '{24,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0};
    ev[2]  = '{125, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 8'd0};
    ev[3]  = '{126, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd0};
    ev[4]  = '{130, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'd0};
    ev[5]  = '{135, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 8'd0};
    ev[6]  = '{140, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4, 8'd0};
    ev[7]  = '{145, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 8'd0};
    ev[8]  = '{150, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 8'd0};
    ev[9]  = '{158, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'd0};
    for (int i = 0; i < 8; i++)
      ev[10 + i] = '{170 + i, 1'b1, 1'b0, (i != 7), 1'b1, 16'(i + 1), ((i == 7) ? 8'd1 : 8'd0)};
    ev[18] = '{178,  1'b0, 1'b0, 1'b0, 1'b0, 16'd8, 8'd1};
    ev[19] = '{200,  1'b0, 1'b0, 1'b0, 1'b0, 16'd8, 8'd1};
    ev[20] = '{201,  1'b0, 1'b0, 1'b1, 1'b0, 16'd8, 8'd1};
    ev[21] = '{210,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'd1};
    ev[22] = '{1000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1};

    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk_40M);
    chk("reset_locked",     32'(locked),     32'd0);
    chk("reset_err_pulse",  32'(err_pulse),  32'd0);
    chk("reset_err_count",  32'(err_count),  32'd0);
    chk("reset_loss_count", 32'(loss_count), 32'd0);
    rst = 1'b0;

    // clean acquisition, single errors, err_clr, window loss and relock
    gen_reset();
    for (int n = 1; n <= 1000; n++) begin
      inv = 1'b0;
      clr = 1'b0;
      hit = -1;
      for (int i = 0; i < NEV; i++) begin
        if (ev[i].n == n) begin
          inv = ev[i].inv;
          clr = ev[i].clr;
          hit = i;
        end
      end
      gen_next(b);
      strobe(b ^ inv, clr, 40);
      cur_n = n;
      if (hit >= 0) begin
        chk("tbl_locked",     32'(locked),     32'(ev[hit].e_lock));
        chk("tbl_err_pulse",  32'(err_pulse),  32'(ev[hit].e_pulse));
        chk("tbl_err_count",  32'(err_count),  32'(ev[hit].e_err));
        chk("tbl_loss_count", 32'(loss_count), 32'(ev[hit].e_loss));
      end
    end

    // pulse must last exactly one cycle
    gen_next(b);
    strobe(~b, 1'b0, 40);
    cur_n = 1001;
    chk("pulse_hi", 32'(err_pulse), 32'd1);
    @(negedge clk_40M);
    chk("pulse_one_cycle", 32'(err_pulse), 32'd0);

    // two more errors -> err_count 3, then one-cycle reset while locked
    for (int n = 1002; n <= 1020; n++) begin
      gen_next(b);
      strobe(b ^ ((n == 1010) || (n == 1015)), 1'b0, 40);
    end
    cur_n = 1020;
    chk("pre_rst_locked",    32'(locked),    32'd1);
    chk("pre_rst_err_count", 32'(err_count), 32'd3);
    pulse_rst();
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_err_count",  32'(err_count),  32'd0);
    chk("rst_loss_count", 32'(loss_count), 32'd0);
    chk("rst_err_pulse",  32'(err_pulse),  32'd0);

    // full reacquisition on the continuing stream: 8 fill + 16 verify
    for (int n = 1; n <= 24; n++) begin
      gen_next(b);
      strobe(b, 1'b0, 40);
      cur_n = 1020 + n;
      if (n == 23) chk("reacq_23_locked", 32'(locked), 32'd0);
      if (n == 24) chk("reacq_24_locked", 32'(locked), 32'd1);
    end

    // all-zero input never leaves HUNT
    pulse_rst();
    saw_lock  = 1'b0;
    saw_pulse = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      strobe(1'b0, 1'b0, 2);
      if (locked)    saw_lock  = 1'b1;
      if (err_pulse) saw_pulse = 1'b1;
    end
    cur_n = 500;
    chk("zero_never_locked", 32'(saw_lock),  32'd0);
    chk("zero_never_pulse",  32'(saw_pulse), 32'd0);
    chk("zero_err_count",    32'(err_count), 32'd0);
    chk("zero_locked_end",   32'(locked),    32'd0);

    // HUNT with saturated fill resumes on real data and locks within 24 bits
    gen_reset();
    for (int n = 1; n <= 24; n++) begin
      gen_next(b);
      strobe(b, 1'b0, 2);
    end
    cur_n = 524;
    chk("after_zero_locked", 32'(locked),    32'd1);
    chk("after_zero_errs",   32'(err_count), 32'd0);

    // err_clr on a non-strobe cycle with no error
    gen_next(b);
    strobe(~b, 1'b0, 2);
    chk("idle_clr_pre", 32'(err_count), 32'd1);
    err_clr = 1'b1;
    @(negedge clk_40M);
    err_clr = 1'b0;
    chk("idle_clr_post", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
